// File: rtl/spi_arb_pkg.sv
// Shared state encoding for the SPI master arbiter.
package spi_arb_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    LAUNCH    = ST_LAUNCH,
    WAIT_BUSY = ST_WAIT_BUSY,
    WAIT_DONE = ST_WAIT_DONE,
    RESP      = ST_RESP
  } state_t;

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester bus plus the spi_master handshake, bundled for the arbiter.
interface spi_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rsp_data;
  logic                      err;
  logic                      spi_start_n;
  logic [DATA_W-1:0]         spi_data_in;
  logic                      spi_busy;
  logic [DATA_W-1:0]         spi_data_out;

  modport slave (
    input  req, req_data, spi_busy, spi_data_out,
    output gnt, done, rsp_data, err, spi_start_n, spi_data_in
  );

  modport master (
    output req, req_data, spi_busy, spi_data_out,
    input  gnt, done, rsp_data, err, spi_start_n, spi_data_in
  );
endinterface

// File: rtl/spi_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_pick
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_pick  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_arbiter.sv
// Round-robin sharing of one spi_master among NUM_REQ requesters.
// Optional transfer watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 200000000
) (
  input logic          CLOCK_50,
  input logic          reset,
  spi_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("spi_arbiter: unsupported parameter set");
  end

  state_t             r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic [DATA_W-1:0]  r_rsp;
  logic [DATA_W-1:0]  r_tx;
  logic               r_err;
  logic               r_start_n;
  logic               r_to;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_win;

  logic [NUM_REQ-1:0] w_pick;
  logic [PTR_W-1:0]   w_pick_idx;
  logic               w_timeout;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req  (bus.req),
    .i_ptr  (r_ptr),
    .o_pick (w_pick)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_pick[k]) w_pick_idx = PTR_W'(k);
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_cnt;

  // Counts cycles since LAUNCH; LAUNCH itself is cycle 0 of the budget.
  always_ff @(posedge CLOCK_50) begin
    if (reset || r_state == IDLE) r_cnt <= '0;
    else if (!w_timeout)          r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout = (r_state == WAIT_BUSY || r_state == WAIT_DONE) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_done    <= '0;
      r_rsp     <= '0;
      r_err     <= 1'b0;
      r_start_n <= 1'b1;
      r_tx      <= '0;
      r_ptr     <= '0;
      r_win     <= '0;
      r_to      <= 1'b0;
    end else begin
      r_done    <= '0;
      r_err     <= 1'b0;
      r_start_n <= 1'b1;
      case (r_state)
        IDLE: begin
          if (|bus.req) begin
            r_gnt   <= w_pick;
            r_win   <= w_pick_idx;
            r_tx    <= bus.req_data[int'(w_pick_idx)*DATA_W +: DATA_W];
            r_to    <= 1'b0;
            r_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_start_n <= 1'b0;
          r_state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (w_timeout) begin
            r_to    <= 1'b1;
            r_rsp   <= '0;
            r_state <= RESP;
          end else if (bus.spi_busy) begin
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (w_timeout) begin
            r_to    <= 1'b1;
            r_rsp   <= '0;
            r_state <= RESP;
          end else if (!bus.spi_busy) begin
            r_rsp   <= bus.spi_data_out;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_done  <= r_gnt;
          r_err   <= r_to;
          r_gnt   <= '0;
          r_ptr   <= (r_win == PTR_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.done        = r_done;
  assign bus.rsp_data    = r_rsp;
  assign bus.err         = r_err;
  assign bus.spi_start_n = r_start_n;
  assign bus.spi_data_in = r_tx;
endmodule
